ysyx_24120013_isram: RTL and testbench

- Instruction-memory responder: the memory end of the instruction-fetch interface driven by the IFU.
- Accepts one fetch request at a time on a valid/ready request channel and returns one 32-bit instruction word on a valid/ready response channel.
- Response arrives after a programmable fixed latency.
- Backing store is an internal word array, preloaded through a separate load port by the simulation harness or boot logic.

---
 rtl/ysyx_24120013_isram_if.sv | 22 ++
 rtl/ysyx_24120013_isram.sv | 98 +++++++++
 tb/tb_ysyx_24120013_isram.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24120013_isram_if.sv
// rtl/ysyx_24120013_isram_if.sv - instruction-fetch request/response bundle between IFU and isram
interface ysyx_24120013_isram_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ysyx_24120013_isram.sv
// rtl/ysyx_24120013_isram.sv - fixed-latency instruction memory responder with preload port
module ysyx_24120013_isram #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_24120013_isram_if.slave     bus,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("ysyx_24120013_isram: LATENCY %0d outside 1..15", LATENCY);
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_next;
  logic                  r_live;
  logic [3:0]            r_cnt, w_cnt_next;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_accept, w_enter, w_fault;
  logic [31:0]           w_addr, w_off;
  logic [AW-1:0]         w_idx;

  // r_live keeps req_ready low until the first edge after reset release
  assign bus.req_ready = r_live && (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_data  = r_data;
  assign bus.rsp_err   = r_err;
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_next = CNT_INIT;
          w_next     = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // With LATENCY==1 the capture edge is the accept edge, so decode the live request address
  assign w_enter = (r_state != S_RESP) && (w_next == S_RESP);
  assign w_addr  = (r_state == S_IDLE) ? bus.req_addr : r_addr;
  assign w_off   = w_addr - BASE_ADDR;
  assign w_fault = (w_addr[1:0] != 2'b00) || (w_off >= SPAN);
  assign w_idx   = w_off[AW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      r_cnt   <= w_cnt_next;
      if (w_accept) r_addr <= bus.req_addr;
      if (w_enter) begin
        r_err  <= w_fault;
        r_data <= w_fault ? '0 : r_mem[w_idx];
      end else if ((r_state == S_RESP) && bus.rsp_ready) begin
        r_err  <= 1'b0;
        r_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end
endmodule

// File: tb/tb_ysyx_24120013_isram.sv
// tb/tb_ysyx_24120013_isram.sv - randomized and directed checks of isram at LATENCY 2 and 3
module tb_ysyx_24120013_isram;
  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic [31:0] mem [1024];
  int          checks = 0;
  int          errors = 0;

  ysyx_24120013_isram_if #(.DATA_WIDTH(32)) if2 ();
  ysyx_24120013_isram_if #(.DATA_WIDTH(32)) if3 ();

  assign if2.req_valid = req_valid & (sel == 1'b0);
  assign if2.req_addr  = req_addr;
  assign if2.rsp_ready = rsp_ready & (sel == 1'b0);
  assign if3.req_valid = req_valid & (sel == 1'b1);
  assign if3.req_addr  = req_addr;
  assign if3.rsp_ready = rsp_ready & (sel == 1'b1);

  wire        o_req_ready = sel ? if3.req_ready : if2.req_ready;
  wire        o_rsp_valid = sel ? if3.rsp_valid : if2.rsp_valid;
  wire [31:0] o_rsp_data  = sel ? if3.rsp_data  : if2.rsp_data;
  wire        o_rsp_err   = sel ? if3.rsp_err   : if2.rsp_err;

  ysyx_24120013_isram #(.DATA_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .bus(if2), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  ysyx_24120013_isram #(.DATA_WIDTH(32), .DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .bus(if3), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a word fetch faults when misaligned or when its offset from the base leaves the 4 KiB window
  task automatic expect_of(input logic [31:0] addr, output logic [31:0] d, output logic e);
    logic [31:0] off;
    off = addr - 32'h8000_0000;
    e   = (addr % 4 != 0) || (off >= 32'd4096);
    d   = e ? 32'd0 : mem[off / 4];
  endtask

  task automatic do_load(input int idx, input logic [31:0] val);
    ld_en   = 1'b1;
    ld_addr = 10'(idx);
    ld_data = val;
    @(posedge clk);
    mem[idx] = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Starts and ends on a falling edge; ld_at>0 schedules a load on edge accept+ld_at
  task automatic fetch(input logic s, input logic [31:0] addr, input int stall,
                       input int ld_at, input int ld_i, input logic [31:0] ld_v,
                       output logic [31:0] od, output logic oe);
    int          lat;
    int          first;
    int          j;
    logic [31:0] ed;
    logic        ee;
    lat = s ? 3 : 2;
    sel = s;
    ed  = 32'd0;
    ee  = 1'b0;
    req_addr  = addr;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    j = 0;
    while (!o_req_ready && j < 20) begin
      @(negedge clk);
      j++;
    end
    chk("accept_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    first = -1;
    for (int k = 0; k < 20; k++) begin
      if (k == lat - 2) expect_of(addr, ed, ee);
      if (o_rsp_valid) begin
        first = k;
        break;
      end
      chk("wait_req_ready", 32'(o_req_ready), 32'd0);
      if (k + 1 == ld_at) begin
        ld_en   = 1'b1;
        ld_addr = 10'(ld_i);
        ld_data = ld_v;
      end
      @(posedge clk);
      if (ld_en) mem[ld_addr] = ld_data;
      @(negedge clk);
      ld_en = 1'b0;
    end
    chk("latency", 32'(first), 32'(lat - 1));
    chk("rsp_data", o_rsp_data, ed);
    chk("rsp_err", 32'(o_rsp_err), 32'(ee));
    od = o_rsp_data;
    oe = o_rsp_err;
    for (int k = 0; k < stall; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 4;
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_data", o_rsp_data, ed);
      chk("hold_err", 32'(o_rsp_err), 32'(ee));
      chk("hold_req_ready", 32'(o_req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(o_rsp_valid), 32'd0);
    chk("post_data", o_rsp_data, 32'd0);
    chk("post_err", 32'(o_rsp_err), 32'd0);
    chk("post_req_ready", 32'(o_req_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
      1:       return 32'h8000_1000 + 32'($urandom_range(0, 255)) * 4;
      2:       return 32'h8000_0000 - 32'($urandom_range(1, 256)) * 4;
      default: return 32'h8000_0000 + 32'($urandom_range(0, 1023)) * 4;
    endcase
  endfunction

  initial begin
    logic [31:0] d;
    logic        e;
    rst       = 1'b1;
    sel       = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = 10'd0;
    ld_data   = 32'd0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 32'({if2.req_ready, if3.req_ready}), 32'd0);
      chk("rst_rsp_valid", 32'({if2.rsp_valid, if3.rsp_valid}), 32'd0);
      chk("rst_rsp_data", if2.rsp_data | if3.rsp_data, 32'd0);
      chk("rst_rsp_err", 32'({if2.rsp_err, if3.rsp_err}), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel_req_ready_low", 32'({if2.req_ready, if3.req_ready}), 32'd0);
    @(negedge clk);
    chk("rel_req_ready_high", 32'({if2.req_ready, if3.req_ready}), 32'd3);
    chk("rel_rsp_valid", 32'({if2.rsp_valid, if3.rsp_valid}), 32'd0);

    for (int i = 0; i < 1024; i++) do_load(i, $urandom);

    do_load(0, 32'h0010_0093);
    fetch(1'b0, 32'h8000_0000, 0, -1, 0, 32'd0, d, e);
    chk("basic_const", d, 32'h0010_0093);

    do_load(5, 32'hDEAD_BEEF);
    fetch(1'b0, 32'h8000_0014, 4, -1, 0, 32'd0, d, e);
    chk("bp_const", d, 32'hDEAD_BEEF);

    fetch(1'b0, 32'h8000_0002, 0, -1, 0, 32'd0, d, e);
    chk("misalign_err", 32'(e), 32'd1);
    chk("misalign_data", d, 32'd0);
    fetch(1'b0, 32'h8000_1000, 1, -1, 0, 32'd0, d, e);
    chk("above_err", 32'(e), 32'd1);
    fetch(1'b0, 32'h7FFF_FFFC, 0, -1, 0, 32'd0, d, e);
    chk("below_err", 32'(e), 32'd1);
    fetch(1'b0, 32'h8000_0FFC, 0, -1, 0, 32'd0, d, e);
    chk("top_word_err", 32'(e), 32'd0);

    sel       = 1'b1;
    req_addr  = 32'h8000_0014;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_wait_valid", 32'(if3.rsp_valid), 32'd0);
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(if3.req_ready), 32'd0);
    chk("midrst_rsp_valid", 32'(if3.rsp_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_hold_valid", 32'(if3.rsp_valid), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_ready", 32'(if3.req_ready), 32'd1);
    chk("midrst_idle_valid", 32'(if3.rsp_valid), 32'd0);
    chk("midrst_idle_data", if3.rsp_data, 32'd0);
    fetch(1'b1, 32'h8000_0014, 0, -1, 0, 32'd0, d, e);
    chk("midrst_refetch", d, 32'hDEAD_BEEF);

    do_load(1, 32'h1111_1111);
    fetch(1'b1, 32'h8000_0004, 0, 1, 1, 32'h2222_2222, d, e);
    chk("race_early_write", d, 32'h2222_2222);
    do_load(1, 32'h1111_1111);
    fetch(1'b1, 32'h8000_0004, 0, 2, 1, 32'h2222_2222, d, e);
    chk("race_capture_edge", d, 32'h1111_1111);
    fetch(1'b1, 32'h8000_0004, 0, -1, 0, 32'd0, d, e);
    chk("race_after", d, 32'h2222_2222);

    for (int i = 0; i < 40; i++) begin
      logic        s;
      logic [31:0] a;
      int          la;
      s  = 1'($urandom_range(0, 1));
      a  = rand_addr();
      la = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 3));
      fetch(s, a, int'($urandom_range(0, 3)), la, int'($urandom_range(0, 1023)), $urandom, d, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
